// File: rtl/alu_result_fifo.sv
// First-word fall-through FIFO buffering ALU results ahead of writeback.
// Define RESULT_FIFO_ZCOUNT_EN to build the saturating popped-zero counter.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_data,
  input  logic          in_z,
  input  logic [AW-1:0] in_dest,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_data,
  output logic          out_z,
  output logic [AW-1:0] out_dest,
  output logic [4:0]    count,
  output logic [7:0]    zcount
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [15:0]   data;
    logic          z;
    logic [AW-1:0] dest;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [4:0]    cnt;
  logic          push;
  logic          pop;

  assign in_ready  = (cnt != 5'(DEPTH));
  assign out_valid = (cnt != 5'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = cnt;

  assign head     = mem[rd_ptr];
  assign out_data = out_valid ? head.data : 16'd0;
  assign out_z    = out_valid ? head.z    : 1'b0;
  assign out_dest = out_valid ? head.dest : '0;

  // Storage is left uncleared on reset; only the pointers matter.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= '{data: in_data, z: in_z, dest: in_dest};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= 5'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 5'd1;
        2'b01:   cnt <= cnt - 5'd1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef RESULT_FIFO_ZCOUNT_EN
  logic [7:0] zcnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zcnt <= 8'd0;
    end else if (pop && head.z && zcnt != 8'hFF) begin
      zcnt <= zcnt + 8'd1;
    end
  end

  assign zcount = zcnt;
`else
  assign zcount = 8'd0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: driver queues expected entries,
// a negedge monitor pops and compares on each accepted pop.
module tb_alu_result_fifo;

  localparam int DEPTH = 4;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          in_z;
  logic [AW-1:0] in_dest;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic          out_z;
  logic [AW-1:0] out_dest;
  logic [4:0]    count;
  logic [7:0]    zcount;

  alu_result_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_z(in_z),
    .in_dest(in_dest),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_z(out_z),
    .out_dest(out_dest),
    .count(count),
    .zcount(zcount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]   d;
    logic          z;
    logic [AW-1:0] dest;
  } ent_t;

  ent_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   mc    = 0;
  int   zm    = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic post_check();
    chk("count", 32'(count), 32'(mc));
    chk("in_ready", 32'(in_ready), 32'(mc != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(mc != 0));
    chk("zcount", 32'(zcount), 32'(zm));
    if (mc == 0) begin
      chk("empty_data", 32'(out_data), 32'd0);
      chk("empty_z", 32'(out_z), 32'd0);
      chk("empty_dest", 32'(out_dest), 32'd0);
    end else if (q.size() > 0) begin
      chk("head_data", 32'(out_data), 32'(q[0].d));
      chk("head_z", 32'(out_z), 32'(q[0].z));
      chk("head_dest", 32'(out_dest), 32'(q[0].dest));
    end
  endtask

  task automatic cycle(input logic iv, input logic [15:0] d,
                       input logic z, input logic [AW-1:0] dest,
                       input logic ordy);
    bit push_e;
    bit pop_e;
    in_valid  = iv;
    in_data   = d;
    in_z      = z;
    in_dest   = dest;
    out_ready = ordy;
    push_e = iv && (mc != DEPTH);
    pop_e  = ordy && (mc != 0);
`ifdef RESULT_FIFO_ZCOUNT_EN
    if (pop_e && q.size() > 0 && q[0].z && zm != 255) zm++;
`endif
    if (push_e) q.push_back('{d: d, z: z, dest: dest});
    mc = mc + int'(push_e) - int'(pop_e);
    @(posedge clk);
    #1;
    post_check();
  endtask

  task automatic do_reset(input logic iv, input logic ordy);
    rst_n     = 1'b0;
    in_valid  = iv;
    in_data   = 16'hDEAD;
    in_z      = 1'b1;
    in_dest   = 8'hEE;
    out_ready = ordy;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    mc = 0;
    zm = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    post_check();
  endtask

  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("pop_unexpected", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("pop_data", 32'(out_data), 32'(e.d));
          chk("pop_z", 32'(out_z), 32'(e.z));
          chk("pop_dest", 32'(out_dest), 32'(e.dest));
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'd0;
    in_z      = 1'b0;
    in_dest   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(1'b0, 1'b0);

    // Single push, visible next cycle
    cycle(1'b1, 16'h0005, 1'b0, 8'h10, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);

    // Fill, overflow attempt, drain
    for (int i = 1; i <= 4; i++)
      cycle(1'b1, 16'(i), 1'(i & 1), 8'(8'h20 + i), 1'b0);
    cycle(1'b1, 16'h00FF, 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);

    // Steady state push+pop at count 2 across wrap
    cycle(1'b1, 16'h0100, 1'b0, 8'h01, 1'b0);
    cycle(1'b1, 16'h0101, 1'b1, 8'h02, 1'b0);
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 16'(16'h0200 + i), 1'(i % 3 == 0), 8'(8'h40 + i), 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);

    // Pop while empty is ignored
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 16'hBEEF, 1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);

    // Reset mid-operation with push and pop requested
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 16'(16'h0300 + i), 1'b0, 8'(i), 1'b0);
    do_reset(1'b1, 1'b1);
    cycle(1'b1, 16'h8001, 1'b0, 8'h7F, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);

    // Zero-flag counter saturation
    for (int i = 0; i < 300; i++)
      cycle(1'b1, 16'(16'h1000 + i), 1'b1, 8'(i), 1'b1);
    cycle(1'b1, 16'h0000, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
`ifdef RESULT_FIFO_ZCOUNT_EN
    chk("zcount_sat", 32'(zcount), 32'd255);
`else
    chk("zcount_off", 32'(zcount), 32'd0);
`endif

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
